// File: rtl/mdl_xfer_seq.sv
// mdl_xfer_seq -- transfer sequencer for one bubble page / bootloader read.
//
// Latches the transfer length when a START is accepted, then counts acquired
// bytes through the effective-data phase (EFF) and the supplementary-data
// phase (SUP). All non-reset updates happen only on 2 MHz enable ticks
// (i_CLK2M_PCEN_n low).
//
// Optional feature: define MDL_XFER_TIMEOUT_EN to build a byte watchdog that
// aborts a stalled transfer after TIMEOUT_TICKS ticks without a strobe.
//
// Ports:
//   i_MCLK          master clock
//   i_RST           synchronous active-high reset (honoured on every edge)
//   i_CLK2M_PCEN_n  active-low clock enable
//   i_START         transfer request (IDLE only)
//   i_ABORT         abort request
//   i_UMODE_n       1 = bootloader transfer, 0 = user page
//   i_4BEN_n        0 = 4-bit mode, 1 = 2-bit mode
//   i_TST           test mode, effective length forced to 1
//   i_BYTE_STB      one byte acquired this tick
//   o_BUSY          not IDLE
//   o_EFFBD         effective-data phase
//   o_SUPBD         supplementary-data phase
//   o_BYTE_CNT      bytes counted in the current phase
//   o_XFER_END      one-tick pulse on normal completion
//   o_ERR           sticky error (abort/timeout), cleared by next START
module mdl_xfer_seq #(
    parameter int BOOT_LEN    = 480,
    parameter int PAGE_LEN_2B = 64,
    parameter int PAGE_LEN_4B = 128,
    parameter int SUP_LEN     = 2
`ifdef MDL_XFER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_TICKS = 1023
`endif
) (
    input  logic       i_MCLK,
    input  logic       i_RST,
    input  logic       i_CLK2M_PCEN_n,
    input  logic       i_START,
    input  logic       i_ABORT,
    input  logic       i_UMODE_n,
    input  logic       i_4BEN_n,
    input  logic       i_TST,
    input  logic       i_BYTE_STB,
    output logic       o_BUSY,
    output logic       o_EFFBD,
    output logic       o_SUPBD,
    output logic [9:0] o_BYTE_CNT,
    output logic       o_XFER_END,
    output logic       o_ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_EFF,
        S_SUP,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] len_q, len_d;
    logic       err_q, err_d;
    logic       tick;
    logic       in_phase;
    logic       abort_req;

    assign tick     = ~i_CLK2M_PCEN_n;
    assign in_phase = (state_q == S_EFF) || (state_q == S_SUP);

`ifdef MDL_XFER_TIMEOUT_EN
    logic [9:0] wd_q, wd_d;
    logic       wd_fire;

    // Watchdog counts strobe-less ticks inside EFF/SUP. It is held at zero
    // outside those phases, so it always starts from zero on EFF entry; the
    // strobe that moves EFF->SUP also clears it, covering SUP entry.
    always_comb begin
        wd_d    = wd_q;
        wd_fire = 1'b0;
        if (tick) begin
            if (!in_phase || i_BYTE_STB) begin
                wd_d = '0;
            end else if (wd_q == 10'(TIMEOUT_TICKS - 1)) begin
                wd_fire = 1'b1;
                wd_d    = '0;
            end else begin
                wd_d = wd_q + 10'd1;
            end
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) wd_q <= '0;
        else       wd_q <= wd_d;
    end

    assign abort_req = i_ABORT | wd_fire;
`else
    assign abort_req = i_ABORT;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = err_q;
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    // Abort in IDLE only masks a simultaneous START.
                    if (i_START && !i_ABORT) begin
                        state_d = S_ARM;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        if (i_TST)          len_d = 10'd1;
                        else if (i_UMODE_n) len_d = 10'(BOOT_LEN);
                        else if (!i_4BEN_n) len_d = 10'(PAGE_LEN_4B);
                        else                len_d = 10'(PAGE_LEN_2B);
                    end
                end
                S_ARM: state_d = S_EFF;
                S_EFF: begin
                    if (i_BYTE_STB) begin
                        if (cnt_q == len_q - 10'd1) begin
                            state_d = S_SUP;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                end
                S_SUP: begin
                    if (i_BYTE_STB) begin
                        if (cnt_q == 10'(SUP_LEN - 1)) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            if (abort_req && state_q != S_IDLE) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign o_BUSY     = (state_q != S_IDLE);
    assign o_EFFBD    = (state_q == S_EFF);
    assign o_SUPBD    = (state_q == S_SUP);
    assign o_XFER_END = (state_q == S_DONE);
    assign o_BYTE_CNT = cnt_q;
    assign o_ERR      = err_q;

endmodule

// File: tb/tb_mdl_xfer_seq.sv
// Directed bench for mdl_xfer_seq. Each step pushes the expected output
// vector {busy,eff,sup,end,err,cnt} onto a scoreboard queue, clocks one MCLK
// edge and pops/compares the entry against the DUT one time unit later.
module tb_mdl_xfer_seq;

    localparam int SUP_LEN = 2;

    logic       clk = 1'b0;
    logic       rst, cen_n, start, abort, umode_n, ben4_n, tst, stb;
    logic       busy, effbd, supbd, xend, err;
    logic [9:0] cnt;

    typedef struct {
        string       tag;
        logic [14:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mdl_xfer_seq #(
        .BOOT_LEN(480), .PAGE_LEN_2B(64), .PAGE_LEN_4B(128), .SUP_LEN(SUP_LEN)
`ifdef MDL_XFER_TIMEOUT_EN
        , .TIMEOUT_TICKS(16)
`endif
    ) dut (
        .i_MCLK(clk), .i_RST(rst), .i_CLK2M_PCEN_n(cen_n), .i_START(start),
        .i_ABORT(abort), .i_UMODE_n(umode_n), .i_4BEN_n(ben4_n), .i_TST(tst),
        .i_BYTE_STB(stb), .o_BUSY(busy), .o_EFFBD(effbd), .o_SUPBD(supbd),
        .o_BYTE_CNT(cnt), .o_XFER_END(xend), .o_ERR(err)
    );

    task automatic step(input string tag, input logic b, e, s, x, er, input int c);
        exp_t ex;
        logic [14:0] obs;
        exp_q.push_back('{tag, {b, e, s, x, er, 10'(c)}});
        @(posedge clk);
        #1;
        ex  = exp_q.pop_front();
        obs = {busy, effbd, supbd, xend, err, cnt};
        checks++;
        assert (obs === ex.v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (busy,eff,sup,end,err,cnt)", ex.tag, obs, ex.v);
        end
    endtask

    // Full normal transfer; mode inputs are scrambled at strobe 'tog' to
    // show the latched length is unaffected.
    task automatic run_xfer(input string tag, input logic um, b4, ts, input int len, input int tog);
        umode_n = um; ben4_n = b4; tst = ts; start = 1'b1; stb = 1'b0;
        step({tag, "_arm"}, 1, 0, 0, 0, 0, 0);
        start = 1'b0; stb = 1'b1;              // strobe in ARM is ignored
        step({tag, "_eff0"}, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < len; i++) begin
            if (i == tog) begin
                ben4_n = ~ben4_n; umode_n = ~umode_n; tst = ~tst;
            end
            if (i < len - 1) step($sformatf("%s_eff%0d", tag, i + 1), 1, 1, 0, 0, 0, i + 1);
            else             step({tag, "_to_sup"}, 1, 0, 1, 0, 0, 0);
        end
        for (int j = 0; j < SUP_LEN; j++) begin
            if (j < SUP_LEN - 1) step($sformatf("%s_sup%0d", tag, j + 1), 1, 0, 1, 0, 0, j + 1);
            else                 step({tag, "_done"}, 1, 0, 0, 1, 0, 0);
        end
        stb = 1'b0;
        step({tag, "_idle"}, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; cen_n = 1'b0; start = 1'b1; abort = 1'b0;
        umode_n = 1'b1; ben4_n = 1'b1; tst = 1'b0; stb = 1'b1;
        step("reset", 0, 0, 0, 0, 0, 0);
        step("reset_hold", 0, 0, 0, 0, 0, 0);
        rst = 1'b0; start = 1'b0; stb = 1'b0;
        step("idle", 0, 0, 0, 0, 0, 0);

        run_xfer("boot", 1'b1, 1'b1, 1'b0, 480, 100);
        run_xfer("pg2b", 1'b0, 1'b1, 1'b0, 64, 10);
        run_xfer("pg4b", 1'b0, 1'b0, 1'b0, 128, 20);
        run_xfer("tst", 1'b1, 1'b1, 1'b1, 1, 0);

        // Abort at cnt=37, with a concurrent strobe losing to abort.
        umode_n = 1'b0; ben4_n = 1'b1; tst = 1'b0; start = 1'b1;
        step("ab_arm", 1, 0, 0, 0, 0, 0);
        start = 1'b0;
        step("ab_eff", 1, 1, 0, 0, 0, 0);
        stb = 1'b1;
        for (int i = 0; i < 37; i++) step($sformatf("ab_eff%0d", i + 1), 1, 1, 0, 0, 0, i + 1);
        abort = 1'b1;
        step("ab_hit", 0, 0, 0, 0, 1, 0);
        stb = 1'b0; start = 1'b1;
        step("ab_idle_start_masked", 0, 0, 0, 0, 1, 0);
        abort = 1'b0;
        step("ab_err_clear", 1, 0, 0, 0, 0, 0);
        start = 1'b0; abort = 1'b1;
        step("ab_in_arm", 0, 0, 0, 0, 1, 0);
        abort = 1'b0;

        // Enable held off: strobes, start and mode changes have no effect.
        start = 1'b1;
        step("cen_arm", 1, 0, 0, 0, 0, 0);
        start = 1'b0;
        step("cen_eff", 1, 1, 0, 0, 0, 0);
        stb = 1'b1;
        for (int i = 0; i < 5; i++) step($sformatf("cen_eff%0d", i + 1), 1, 1, 0, 0, 0, i + 1);
        cen_n = 1'b1; start = 1'b1; ben4_n = 1'b0;
        for (int i = 0; i < 50; i++) step($sformatf("cen_hold%0d", i), 1, 1, 0, 0, 0, 5);
        cen_n = 1'b0; start = 1'b0; ben4_n = 1'b1;
        for (int i = 5; i < 63; i++) step($sformatf("cen_eff%0d", i + 1), 1, 1, 0, 0, 0, i + 1);
        step("cen_to_sup", 1, 0, 1, 0, 0, 0);

        // START in SUP and DONE ignored; held START restarts from IDLE.
        start = 1'b1;
        step("sup_start_ign", 1, 0, 1, 0, 0, 1);
        step("sup_done", 1, 0, 0, 1, 0, 0);
        step("done_start_ign", 0, 0, 0, 0, 0, 0);
        step("restart_arm", 1, 0, 0, 0, 0, 0);
        start = 1'b0;
        step("restart_eff", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 63; i++) step($sformatf("rs_eff%0d", i + 1), 1, 1, 0, 0, 0, i + 1);
        step("rs_to_sup", 1, 0, 1, 0, 0, 0);
        step("rs_sup1", 1, 0, 1, 0, 0, 1);
        rst = 1'b1;
        step("rst_mid_sup", 0, 0, 0, 0, 0, 0);
        rst = 1'b0; stb = 1'b0;

        // Stalled transfer.
        start = 1'b1;
        step("to_arm", 1, 0, 0, 0, 0, 0);
        start = 1'b0;
        step("to_eff", 1, 1, 0, 0, 0, 0);
`ifdef MDL_XFER_TIMEOUT_EN
        for (int i = 0; i < 15; i++) step($sformatf("to_wait%0d", i), 1, 1, 0, 0, 0, 0);
        step("to_fire", 0, 0, 0, 0, 1, 0);
`else
        for (int i = 0; i < 2000; i++) step($sformatf("to_wait%0d", i), 1, 1, 0, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdl_xfer_seq.md
Name: mdl_xfer_seq

Overview:
- Transfer sequencer for one bubble page/bootloader read.
- Latches the transfer mode and counts acquired bytes through the effective-data phase and then the supplementary-data phase.
- Outputs phase flags, a byte count and an end pulse; the data length evaluator and the byte acquisition logic use these to time supplementary-data start and end.
- Sits between the host command decoder and the byte acquisition datapath. All state advances on the 2 MHz clock enable.

Parameters:
- BOOT_LEN, 480, effective bytes per bootloader transfer (UMODE_n=1).
- PAGE_LEN_2B, 64, effective bytes per user page in 2-bit mode.
- PAGE_LEN_4B, 128, effective bytes per user page in 4-bit mode.
- SUP_LEN, 2, supplementary bytes after effective data (1..15).
- TIMEOUT_TICKS, 1023, CEN ticks without a byte before abort (optional feature only).

Ports:
- i_MCLK  in  1  master clock.
- i_RST  in  1  synchronous active-high reset, sampled every MCLK edge regardless of CEN.
- i_CLK2M_PCEN_n  in  1  active-low clock enable; all non-reset updates occur only when low.
- i_START  in  1  transfer request, level sampled on a CEN tick.
- i_ABORT  in  1  abort request.
- i_UMODE_n  in  1  1 = bootloader transfer, 0 = user page transfer.
- i_4BEN_n  in  1  0 = 4-bit mode, 1 = 2-bit mode.
- i_TST  in  1  test mode: effective length forced to 1.
- i_BYTE_STB  in  1  one byte acquired this tick.
- o_BUSY  out  1  state not IDLE.
- o_EFFBD  out  1  effective-data phase active.
- o_SUPBD  out  1  supplementary-data phase active.
- o_BYTE_CNT  out  10  bytes counted in the current phase.
- o_XFER_END  out  1  one-tick pulse on normal completion.
- o_ERR  out  1  sticky error flag; set on abort or timeout, cleared by the next accepted START.

Behaviour:
- Reset: state=IDLE, and all outputs are 0, including o_BYTE_CNT and o_ERR.
- "Tick" means an MCLK edge with i_CLK2M_PCEN_n=0. Inputs are ignored on non-tick edges.
- FSM states: IDLE, ARM, EFF, SUP, DONE.
- IDLE: if i_START=1, go to ARM.
  - Latch len: BOOT_LEN if i_UMODE_n=1; otherwise PAGE_LEN_4B if i_4BEN_n=0, else PAGE_LEN_2B. If i_TST=1, len=1.
  - Clear o_ERR and o_BYTE_CNT.
- ARM: exactly one tick, then go to EFF. i_BYTE_STB is ignored in ARM.
- EFF: o_EFFBD=1. On i_BYTE_STB, cnt increments.
  - If the strobe arrives with cnt==len-1, go to SUP with cnt=0 instead of incrementing. o_EFFBD falls and o_SUPBD rises on the same tick.
- SUP: o_SUPBD=1. Counts i_BYTE_STB up to SUP_LEN using the same rule, then goes to DONE with cnt=0.
- DONE: o_XFER_END=1 for this one tick, then go to IDLE.
- Latched mode bits are not re-sampled mid-transfer. Input changes after ARM have no effect.
- i_START outside IDLE is ignored, including in DONE. i_START held high through DONE starts a new transfer from IDLE on the following tick.
- i_ABORT in ARM/EFF/SUP/DONE: go to IDLE on that tick, set o_ERR=1, clear cnt, no o_XFER_END.
- i_ABORT in IDLE: no effect, except that i_START in the same tick is ignored.
- Priority: i_RST > i_ABORT > i_START / i_BYTE_STB.
- i_RST mid-transfer: return to IDLE and zero all outputs on that edge.
- Latency: START tick to o_EFFBD=1 is 2 ticks. Last supplementary byte tick to o_XFER_END is 1 tick.
- Counter width is 10 bits. Parameters must satisfy len ≤ 1023; the counter never wraps in legal use.

Optional Feature:
- Macro: MDL_XFER_TIMEOUT_EN.
- Defined:
  - A 10-bit watchdog counts ticks in EFF/SUP without i_BYTE_STB. It resets on each strobe and on phase entry.
  - When the watchdog reaches TIMEOUT_TICKS, the block behaves exactly as i_ABORT (IDLE, o_ERR=1).
- Undefined: no watchdog logic is generated, and a stalled transfer waits indefinitely.

Test Plan:
- Reset, then START with UMODE_n=1 → o_EFFBD high 2 ticks later; after 480 strobes, o_SUPBD=1 with cnt=0; after 2 more strobes, o_XFER_END pulses once; then o_BUSY=0.
- UMODE_n=0, 4BEN_n=1 → EFF lasts exactly 64 strobes. UMODE_n=0, 4BEN_n=0 → EFF lasts exactly 128 strobes. Toggle 4BEN_n during EFF → length unchanged.
- TST=1 with UMODE_n=1 → single strobe ends EFF; end pulse after 1+SUP_LEN strobes.
- ABORT at cnt=37 in EFF → next tick IDLE, o_ERR=1, o_BYTE_CNT=0, no o_XFER_END. Next START → o_ERR clears.
- CEN held high for 50 MCLKs with strobes asserted → no count change. START during SUP → ignored. i_RST mid-SUP → all outputs 0 on the same edge.
- With MDL_XFER_TIMEOUT_EN and TIMEOUT_TICKS=16 → no strobe for 16 ticks in EFF gives o_ERR=1 and IDLE. Without the macro → still in EFF after 2000 ticks.
